// File: rtl/conv_pkg.sv
// conv_pkg
//   Shared definitions for the convolution datapath: default window geometry,
//   the flattened window width and the element-index helper used by both the
//   window generator and the convolution calculator.
//   Ports: none (package).
package conv_pkg;

  localparam int DATA_BITS   = 8;
  localparam int FILTER_SIZE = 5;
  localparam int WIN_BITS    = FILTER_SIZE * FILTER_SIZE * DATA_BITS;

  // Flattened position of window element (r, c): r=0 is the oldest row,
  // c=0 the oldest column.
  function automatic int win_idx(input int r, input int c, input int fs = FILTER_SIZE);
    return r * fs + c;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf
//   One image-row delay line built as a circular RAM addressed by the current
//   column. Reading and writing the same column address on an accept returns
//   the pixel stored one full row earlier, then overwrites it.
//   Ports:
//     clk     in  rising-edge clock
//     en_i    in  pixel accepted this cycle (advances the delay)
//     addr_i  in  column of the accepted pixel
//     data_i  in  pixel entering the delay
//     data_o  out pixel from the same column one row earlier
module conv_line_buf #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 28,
  parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [DATA_BITS-1:0] data_o
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  // The RAM is deliberately never cleared: stale contents only feed windows
  // that the generator's valid gating suppresses.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem[addr_i] <= data_i;
    end
  end

  // Asynchronous read so the old value is available in the accept cycle.
  assign data_o = mem[addr_i];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Sliding-window generator for a raster-scan feature map. Produces one
//   flattened FILTER_SIZE x FILTER_SIZE window for every position where the
//   window lies fully inside the image (no padding, stride 1).
//   Ports:
//     clk         in  rising-edge clock
//     rst_n       in  asynchronous active-low reset
//     in_val      in  pixel_in valid this cycle, no backpressure
//     sof         in  start of frame, restarts the raster counters
//     pixel_in    in  input pixel (signed, passed through untouched)
//     data_out    out window, element i at [i*DATA_BITS +: DATA_BITS]
//     out_val     out data_out holds a complete window (1-cycle pulse)
//     frame_done  out pulse after the last pixel of a frame is accepted
module conv_window_gen #(
  parameter int FILTER_SIZE = conv_pkg::FILTER_SIZE,
  parameter int DATA_BITS   = conv_pkg::DATA_BITS,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_val,
  input  logic                                     sof,
  input  logic [DATA_BITS-1:0]                     pixel_in,
  output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] data_out,
  output logic                                     out_val,
  output logic                                     frame_done
);

  import conv_pkg::*;

  localparam int WIN_W = FILTER_SIZE * FILTER_SIZE * DATA_BITS;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] FIRST_WIN_COL = COL_W'(FILTER_SIZE - 1);
  localparam logic [ROW_W-1:0] FIRST_WIN_ROW = ROW_W'(FILTER_SIZE - 1);

  logic [COL_W-1:0] col_q, col_d, posCol;
  logic [ROW_W-1:0] row_q, row_d, posRow;
  logic [WIN_W-1:0] win_q, win_d;
  logic             outVal_q, outVal_d;
  logic             frameDone_q, frameDone_d;

  // taps[0] is the live pixel; taps[k] is the same column k rows earlier.
  logic [FILTER_SIZE-1:0][DATA_BITS-1:0] taps;

  // A pixel arriving together with sof is treated as (0,0), so the position
  // used for this cycle's decisions overrides the stored counters.
  always_comb begin
    posCol = sof ? '0 : col_q;
    posRow = sof ? '0 : row_q;
  end

  // Raster counters: column wraps into the next row, row wraps into the next
  // frame. A lone sof (no pixel) only rewinds to (0,0).
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_val) begin
      if (posCol == LAST_COL) begin
        col_d = '0;
        row_d = (posRow == LAST_ROW) ? '0 : posRow + 1'b1;
      end else begin
        col_d = posCol + 1'b1;
        row_d = posRow;
      end
    end else if (sof) begin
      col_d = '0;
      row_d = '0;
    end
  end

  assign taps[0] = pixel_in;

  // Cascaded row delays all share the column address, so tap k always lines
  // up with the column of the pixel being accepted.
  for (genvar k = 1; k < FILTER_SIZE; k++) begin : g_line_buf
    conv_line_buf #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (IMG_W),
      .ADDR_W    (COL_W)
    ) u_line_buf (
      .clk    (clk),
      .en_i   (in_val),
      .addr_i (posCol),
      .data_i (taps[k-1]),
      .data_o (taps[k])
    );
  end

  // Window shift: each column moves one place older and the new rightmost
  // column is filled top-to-bottom from the oldest tap down to the live pixel.
  always_comb begin
    win_d = win_q;
    if (in_val) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE; c++) begin
          if (c == FILTER_SIZE - 1) begin
            win_d[win_idx(r, c, FILTER_SIZE)*DATA_BITS +: DATA_BITS] = taps[FILTER_SIZE-1-r];
          end else begin
            win_d[win_idx(r, c, FILTER_SIZE)*DATA_BITS +: DATA_BITS] =
              win_q[win_idx(r, c + 1, FILTER_SIZE)*DATA_BITS +: DATA_BITS];
          end
        end
      end
    end
  end

  // Valid gating: the column condition also hides the windows that would
  // otherwise straddle the previous row after every row start.
  always_comb begin
    outVal_d    = in_val && (posRow >= FIRST_WIN_ROW) && (posCol >= FIRST_WIN_COL);
    frameDone_d = in_val && (posRow == LAST_ROW) && (posCol == LAST_COL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      outVal_q    <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      outVal_q    <= outVal_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign data_out   = win_q;
  assign out_val    = outVal_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen
//   Bench for conv_window_gen with a 3x3 window over an 8x8 image.
//   A reference image store rebuilds every expected window as pixels are
//   driven and queues it; the monitor pops and compares on each out_val.
module tb_conv_window_gen;

  localparam int F  = 3;
  localparam int DB = 8;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int WB = F * F * DB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_val;
  logic          sof;
  logic [DB-1:0] pixel_in;
  logic [WB-1:0] data_out;
  logic          out_val;
  logic          frame_done;

  always #5 clk = ~clk;

  conv_window_gen #(
    .FILTER_SIZE (F),
    .DATA_BITS   (DB),
    .IMG_W       (W),
    .IMG_H       (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_val     (in_val),
    .sof        (sof),
    .pixel_in   (pixel_in),
    .data_out   (data_out),
    .out_val    (out_val),
    .frame_done (frame_done)
  );

  typedef struct {
    string name;
    int    scen;
    int    logIdx;
    int    topLeft;
  } spot_t;

  int            assertCount = 0;
  int            failCount   = 0;
  logic [WB-1:0] expQ [$];
  logic [WB-1:0] winLog [$];
  logic [WB-1:0] refLog [$];
  logic          expOv = 1'b0;
  logic          expFd = 1'b0;
  int            winCount = 0;
  int            fdCount  = 0;
  logic [DB-1:0] img [H][W];
  int            mRow = 0;
  int            mCol = 0;
  spot_t         spots [5];

  task automatic checkOutput(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected window whose top-left pixel value is tl, for images whose
  // pixel value is base + row*W + col.
  function automatic logic [WB-1:0] mkWin(input int tl);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < F; r++)
      for (int c = 0; c < F; c++)
        w[(r*F+c)*DB +: DB] = DB'(tl + r*W + c);
    return w;
  endfunction

  // Drive one cycle at the falling edge and update the reference model.
  task automatic applyStimulus(input logic v, input logic s, input logic [DB-1:0] pix);
    logic [WB-1:0] w;
    @(negedge clk);
    in_val   = v;
    sof      = s;
    pixel_in = pix;
    if (s) begin
      mRow = 0;
      mCol = 0;
    end
    expOv = 1'b0;
    expFd = 1'b0;
    if (v) begin
      img[mRow][mCol] = pix;
      if (mRow >= F-1 && mCol >= F-1) begin
        w = '0;
        for (int r = 0; r < F; r++)
          for (int c = 0; c < F; c++)
            w[(r*F+c)*DB +: DB] = img[mRow-F+1+r][mCol-F+1+c];
        expQ.push_back(w);
        expOv = 1'b1;
      end
      if (mRow == H-1 && mCol == W-1) expFd = 1'b1;
      if (mCol == W-1) begin
        mCol = 0;
        mRow = (mRow == H-1) ? 0 : mRow + 1;
      end else begin
        mCol = mCol + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, DB'($urandom));
  endtask

  task automatic sendPixels(input int base, input int first, input int last, input int idlePct);
    for (int p = first; p <= last; p++) begin
      while ($urandom_range(0, 99) < idlePct) applyStimulus(1'b0, 1'b0, DB'($urandom));
      applyStimulus(1'b1, 1'b0, DB'(base + p));
    end
  endtask

  task automatic clearCounts();
    winCount = 0;
    fdCount  = 0;
    winLog.delete();
  endtask

  task automatic checkSpots(input int scen);
    for (int i = 0; i < 5; i++) begin
      if (spots[i].scen == scen) begin
        if (spots[i].logIdx < winLog.size())
          checkOutput(spots[i].name, winLog[spots[i].logIdx], mkWin(spots[i].topLeft));
        else
          checkOutput(spots[i].name, WB'(winLog.size()), WB'(spots[i].logIdx + 1));
      end
    end
  endtask

  task automatic checkSameAsRef(input string name);
    int diffs;
    diffs = (winLog.size() == refLog.size()) ? 0 : 1;
    for (int i = 0; i < winLog.size() && i < refLog.size(); i++)
      if (winLog[i] !== refLog[i]) diffs++;
    checkOutput(name, WB'(diffs), WB'(0));
  endtask

  // Monitor: sample shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    checkOutput("out_val", WB'(out_val), WB'(expOv));
    checkOutput("frame_done", WB'(frame_done), WB'(expFd));
    if (out_val === 1'b1) begin
      winCount++;
      winLog.push_back(data_out);
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL window_queue: got unexpected window %h expected none", data_out);
      end else begin
        checkOutput("window", data_out, expQ.pop_front());
      end
    end
    if (frame_done === 1'b1) fdCount++;
  end

  initial begin
    spots[0] = '{"s1_first_window", 1, 0, 0};
    spots[1] = '{"s3_row_boundary", 1, 6, 8};
    spots[2] = '{"s1_last_window", 1, 35, 45};
    spots[3] = '{"s4_frame2_first", 4, 36, 64};
    spots[4] = '{"s5_restart_first", 5, 2, 0};

    rst_n    = 1'b0;
    in_val   = 1'b0;
    sof      = 1'b0;
    pixel_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_data_out", data_out, '0);
    checkOutput("reset_out_val", WB'(out_val), WB'(0));
    checkOutput("reset_frame_done", WB'(frame_done), WB'(0));
    rst_n = 1'b1;

    $display("[TB] scenario 1: full frame");
    clearCounts();
    sendPixels(0, 0, W*H-1, 0);
    idle(3);
    checkOutput("s1_window_count", WB'(winCount), WB'(36));
    checkOutput("s1_frame_done_count", WB'(fdCount), WB'(1));
    checkSpots(1);
    refLog = winLog;

    $display("[TB] scenario 2: random idle gaps");
    clearCounts();
    sendPixels(0, 0, W*H-1, 40);
    idle(3);
    checkOutput("s2_window_count", WB'(winCount), WB'(36));
    checkOutput("s2_frame_done_count", WB'(fdCount), WB'(1));
    checkSameAsRef("s2_same_windows");

    $display("[TB] scenario 4: back-to-back frames");
    clearCounts();
    sendPixels(0, 0, W*H-1, 0);
    sendPixels(64, 0, W*H-1, 0);
    idle(3);
    checkOutput("s4_window_count", WB'(winCount), WB'(72));
    checkOutput("s4_frame_done_count", WB'(fdCount), WB'(2));
    checkSpots(4);
    begin
      int viol;
      viol = 0;
      for (int i = 36; i < winLog.size(); i++)
        for (int e = 0; e < F*F; e++)
          if (winLog[i][e*DB +: DB] < 8'd64) viol++;
      checkOutput("s4_no_frame1_values", WB'(viol), WB'(0));
    end

    $display("[TB] scenario 5a: sof with pixel");
    clearCounts();
    sendPixels(0, 0, 19, 0);
    applyStimulus(1'b1, 1'b1, 8'd0);
    sendPixels(0, 1, W*H-1, 0);
    idle(3);
    checkOutput("s5a_window_count", WB'(winCount), WB'(38));
    checkOutput("s5a_frame_done_count", WB'(fdCount), WB'(1));
    checkSpots(5);

    $display("[TB] scenario 5b: sof alone");
    clearCounts();
    sendPixels(0, 0, 19, 0);
    applyStimulus(1'b0, 1'b1, DB'($urandom));
    sendPixels(0, 0, W*H-1, 0);
    idle(3);
    checkOutput("s5b_window_count", WB'(winCount), WB'(38));
    checkOutput("s5b_frame_done_count", WB'(fdCount), WB'(1));
    checkSpots(5);

    $display("[TB] scenario 6: reset mid-frame");
    sendPixels(0, 0, 20, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_data_out", data_out, '0);
    checkOutput("s6_rst_out_val", WB'(out_val), WB'(0));
    checkOutput("s6_rst_frame_done", WB'(frame_done), WB'(0));
    in_val = 1'b0;
    sof    = 1'b0;
    expOv  = 1'b0;
    expFd  = 1'b0;
    mRow   = 0;
    mCol   = 0;
    expQ.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    clearCounts();
    sendPixels(0, 0, W*H-1, 0);
    idle(3);
    checkOutput("s6_window_count", WB'(winCount), WB'(36));
    checkOutput("s6_frame_done_count", WB'(fdCount), WB'(1));
    checkSameAsRef("s6_same_windows");

    checkOutput("scoreboard_empty", WB'(expQ.size()), WB'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
